// File: rtl/vdc_bg_fetch_pkg.sv
// -----------------------------------------------------------------------------
// VDCDefines: shared types and constants for the VDC background fetch engine.
//   bat_entry_t  - one BAT word: palette in [15:12], tile index in [11:0]
//   tile_line_t  - one fetched 8-pixel char row: palette + CG0 + CG1 planes
//   SLOT_*       - position of each VRAM read inside the 8-clock char slot
//   map_width_e  - decoded virtual-screen width
//   bat_addr()   - row/column to BAT word address for the current map size
// -----------------------------------------------------------------------------
package VDCDefines;

    localparam logic [2:0] SLOT_BAT  = 3'd0;
    localparam logic [2:0] SLOT_CG0  = 3'd4;
    localparam logic [2:0] SLOT_CG1  = 3'd6;
    localparam logic [2:0] SLOT_LAST = 3'd7;

    typedef enum logic [1:0] {
        MAP_W32  = 2'b00,
        MAP_W64  = 2'b01,
        MAP_W128 = 2'b10
    } map_width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_RUN,
        ST_DONE
    } bg_state_e;

    typedef struct packed {
        logic [3:0]  palette;
        logic [11:0] tile;
    } bat_entry_t;

    typedef struct packed {
        logic [3:0]  palette;
        logic [15:0] cg0;
        logic [15:0] cg1;
    } tile_line_t;

    // scr_w = 2'b11 is treated as 128 wide, same as 2'b10.
    function automatic map_width_e decode_width(input logic [1:0] scr_w);
        if (scr_w[1]) begin
            return MAP_W128;
        end else if (scr_w[0]) begin
            return MAP_W64;
        end else begin
            return MAP_W32;
        end
    endfunction

    // row*W + col with col < W is a plain concatenation of row and col bits.
    function automatic logic [15:0] bat_addr(
        input logic [5:0] map_row,
        input logic [6:0] tile_col,
        input logic [1:0] scr_w,
        input logic       scr_h
    );
        logic [5:0]  row;
        logic [15:0] addr;
        row = scr_h ? map_row : {1'b0, map_row[4:0]};
        case (decode_width(scr_w))
            MAP_W32: addr = {5'd0, row, tile_col[4:0]};
            MAP_W64: addr = {4'd0, row, tile_col[5:0]};
            default: addr = {3'd0, row, tile_col};
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/vdc_bg_fetch_shifter.sv
// -----------------------------------------------------------------------------
// vdc_bg_shifter: 8-pixel serialiser for one tile_line_t.
//   clock, reset : pixel clock, asynchronous active-high reset
//   load         : take line_in this clock (its pixel 0 is output immediately)
//   shift        : advance one pixel per clock
//   line_in      : char row to serialise
//   pixel        : {0, palette, CG1 hi, CG1 lo, CG0 hi, CG0 lo} of current pixel
// -----------------------------------------------------------------------------
module vdc_bg_shifter
    import VDCDefines::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  tile_line_t line_in,
    output logic [8:0] pixel
);

    tile_line_t line_reg;
    tile_line_t src;

    // On a load clock the new line is presented directly so pixel 0 appears
    // in the same clock as the load, without an extra pipeline stage.
    always_comb begin
        src = load ? line_in : line_reg;
    end

    // Bits 15 and 7 of each plane hold the current pixel; shifting the whole
    // word left drains the upper and lower bytes in lockstep.
    assign pixel = {1'b0, src.palette, src.cg1[15], src.cg1[7], src.cg0[15], src.cg0[7]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_reg <= '0;
        end else if (shift) begin
            line_reg.palette <= src.palette;
            line_reg.cg0     <= {src.cg0[14:0], 1'b0};
            line_reg.cg1     <= {src.cg1[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/vdc_bg_fetch.sv
// -----------------------------------------------------------------------------
// vdc_bg_fetch: HuC6270 background fetch / serialiser engine.
// Fetches BAT + CG0 + CG1 for each char in a fixed 8-clock slot, keeps
// PIPE_LEN chars in flight and serialises one 9-bit VD pixel per clock.
//   clock, reset      : pixel/VRAM clock, asynchronous active-high reset
//   line_start        : 1-clk pulse, (re)start the current scanline at slot 0
//   active            : display enable; low forces IDLE
//   bxr, byr          : X scroll in pixels, Y scroll + line in pixels
//   scr_w, scr_h      : map size (32/64/128 wide, 32/64 high, in tiles)
//   hdw               : displayed tiles minus 1
//   vram_addr/vram_rd : VRAM read request, data returns next clock on vram_data
//   slot_free         : VRAM slot not used by BG, CPU may take it
//   pix_valid/pix_out : displayed pixel toward the VCE (0 when not valid)
//   line_done         : 1-clk pulse after the last pixel of the line
// -----------------------------------------------------------------------------
module vdc_bg_fetch
    import VDCDefines::*;
#(
    parameter int PIPE_LEN = 2,
    parameter int ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              line_start,
    input  logic              active,
    input  logic [9:0]        bxr,
    input  logic [8:0]        byr,
    input  logic [1:0]        scr_w,
    input  logic              scr_h,
    input  logic [6:0]        hdw,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    input  logic [15:0]       vram_data,
    output logic              slot_free,
    output logic              pix_valid,
    output logic [8:0]        pix_out,
    output logic              line_done
);

    localparam logic [9:0] PREFETCH_LAST = 10'(PIPE_LEN - 1);

    bg_state_e   state_reg, state_next;
    logic [2:0]  slot_reg;
    logic [9:0]  char_reg;      // char slots elapsed since line start
    logic [10:0] pix_reg;       // pixels serialised in RUN, fine-scroll ones included
    bat_entry_t  bat_reg;
    logic [15:0] cg0_reg;
    tile_line_t  pipe_reg [PIPE_LEN];

    logic        fetching;
    logic        fetch_en;
    logic        running;
    logic [6:0]  tile_col;
    logic [10:0] vis_start;
    logic [10:0] vis_end;
    logic [10:0] vis_last;
    logic        in_window;
    logic [15:0] addr16;
    logic [8:0]  shift_pixel;

    // ---------------------------------------------------------------- control
    always_comb begin
        fetching  = (state_reg == ST_PREFETCH) || (state_reg == ST_RUN);
        // hdw+2 chars: the extra one covers the pixels pushed out by fine scroll
        fetch_en  = fetching && (char_reg < (10'(hdw) + 10'd2));
        running   = (state_reg == ST_RUN);
        // 7-bit add wraps at 128; the BAT function masks down to 32/64
        tile_col  = bxr[9:3] + char_reg[6:0];
        vis_start = {8'd0, bxr[2:0]};
        vis_end   = vis_start + {({1'b0, hdw} + 8'd1), 3'b000};
        vis_last  = vis_end - 11'd1;
        in_window = (pix_reg >= vis_start) && (pix_reg < vis_end);
    end

    always_comb begin
        state_next = state_reg;
        if (!active) begin
            state_next = ST_IDLE;
        end else if (line_start) begin
            state_next = ST_PREFETCH;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_PREFETCH: begin
                    if ((slot_reg == SLOT_LAST) && (char_reg == PREFETCH_LAST)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pix_reg == vis_last) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------- VRAM requests
    always_comb begin
        addr16  = 16'h0000;
        vram_rd = 1'b0;
        if (fetch_en) begin
            case (slot_reg)
                SLOT_BAT: begin
                    vram_rd = 1'b1;
                    addr16  = bat_addr(byr[8:3], tile_col, scr_w, scr_h);
                end
                SLOT_CG0: begin
                    vram_rd = 1'b1;
                    addr16  = {bat_reg.tile, 1'b0, byr[2:0]};
                end
                SLOT_CG1: begin
                    vram_rd = 1'b1;
                    addr16  = {bat_reg.tile, 1'b1, byr[2:0]};
                end
                default: ;
            endcase
        end
    end

    assign vram_addr = ADDR_W'(addr16);
    assign slot_free = ~vram_rd;

    // ------------------------------------------------- counters, capture, pipe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_reg <= '0;
            char_reg <= '0;
            pix_reg  <= '0;
            bat_reg  <= '0;
            cg0_reg  <= '0;
            for (int i = 0; i < PIPE_LEN; i++) begin
                pipe_reg[i] <= '0;
            end
        end else if (!active || line_start) begin
            // restart (or drop) the line: next clock is slot 0 of char 0
            slot_reg <= '0;
            char_reg <= '0;
            pix_reg  <= '0;
            bat_reg  <= '0;
            cg0_reg  <= '0;
            for (int i = 0; i < PIPE_LEN; i++) begin
                pipe_reg[i] <= '0;
            end
        end else if (state_reg != ST_IDLE) begin
            slot_reg <= slot_reg + 3'd1;
            if (slot_reg == SLOT_LAST) begin
                char_reg <= char_reg + 10'd1;
            end
            if (running) begin
                pix_reg <= pix_reg + 11'd1;
            end
            // read data arrives one clock after each request slot
            if (fetch_en && (slot_reg == SLOT_BAT + 3'd1)) begin
                bat_reg <= bat_entry_t'(vram_data);
            end
            if (fetch_en && (slot_reg == SLOT_CG0 + 3'd1)) begin
                cg0_reg <= vram_data;
            end
            // the pipe keeps advancing after fetch stops so the head still moves
            if (fetching && (slot_reg == SLOT_LAST)) begin
                for (int i = PIPE_LEN - 1; i > 0; i--) begin
                    pipe_reg[i] <= pipe_reg[i-1];
                end
                pipe_reg[0] <= fetch_en ? {bat_reg.palette, cg0_reg, vram_data} : '0;
            end
        end
    end

    // ------------------------------------------------------------- serialiser
    vdc_bg_shifter u_shifter (
        .clock   (clock),
        .reset   (reset),
        .load    (running && (slot_reg == SLOT_BAT)),
        .shift   (running),
        .line_in (pipe_reg[PIPE_LEN-1]),
        .pixel   (shift_pixel)
    );

    assign pix_valid = running && in_window;
    assign pix_out   = pix_valid ? shift_pixel : 9'h000;
    assign line_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_vdc_bg_fetch.sv
// -----------------------------------------------------------------------------
// tb_vdc_bg_fetch: directed bench for vdc_bg_fetch (PIPE_LEN=2, ADDR_W=16).
// A small VRAM array answers reads one clock later. Each line is run with a
// cycle budget; addresses, pixels and line_done timing are captured and
// compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_vdc_bg_fetch;

    localparam int BUDGET = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        line_start;
    logic        active;
    logic [9:0]  bxr;
    logic [8:0]  byr;
    logic [1:0]  scr_w;
    logic        scr_h;
    logic [6:0]  hdw;
    logic [15:0] vram_addr;
    logic        vram_rd;
    logic [15:0] vram_data = 16'h0000;
    logic        slot_free;
    logic        pix_valid;
    logic [8:0]  pix_out;
    logic        line_done;

    logic [15:0] mem [0:65535];

    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [15:0] rd_q[$];
    logic [8:0]  pix_q[$];
    logic [8:0]  po_at   [0:BUDGET];
    logic        pv_at   [0:BUDGET];
    logic        rdv_at  [0:BUDGET];
    logic [15:0] addr_at [0:BUDGET];
    int          first_valid;
    int          done_cnt;
    int          done_c;
    int          extra_done;

    always #5 clock = ~clock;

    vdc_bg_fetch #(
        .PIPE_LEN (2),
        .ADDR_W   (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .line_start (line_start),
        .active     (active),
        .bxr        (bxr),
        .byr        (byr),
        .scr_w      (scr_w),
        .scr_h      (scr_h),
        .hdw        (hdw),
        .vram_addr  (vram_addr),
        .vram_rd    (vram_rd),
        .vram_data  (vram_data),
        .slot_free  (slot_free),
        .pix_valid  (pix_valid),
        .pix_out    (pix_out),
        .line_done  (line_done)
    );

    // VRAM: data for a read issued this clock is presented the next clock
    always @(posedge clock) begin
        vram_data <= vram_rd ? mem[vram_addr] : 16'h0000;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulses line_start, then records every clock until line_done or budget.
    // restart_at > 0 pulses line_start again in that cycle; recording of
    // queues and relative timing then restarts for the new line.
    task automatic run_line(input int restart_at);
        int c;
        int cstart;
        rd_q.delete();
        pix_q.delete();
        first_valid = -1;
        done_cnt    = 0;
        done_c      = -1;
        extra_done  = 0;
        cstart      = 0;
        line_start  = 1'b1;
        tick();
        line_start  = 1'b0;
        c = 1;
        while ((done_cnt == 0) && (c < BUDGET)) begin
            po_at[c]   = pix_out;
            pv_at[c]   = pix_valid;
            rdv_at[c]  = vram_rd;
            addr_at[c] = vram_addr;
            if (vram_rd) rd_q.push_back(vram_addr);
            if (pix_valid) begin
                if (first_valid < 0) first_valid = c - cstart;
                pix_q.push_back(pix_out);
            end
            if (line_done) begin
                done_cnt++;
                done_c = c - cstart;
            end
            if (c == restart_at) begin
                line_start  = 1'b1;
                cstart      = c;
                rd_q.delete();
                pix_q.delete();
                first_valid = -1;
            end
            tick();
            line_start = 1'b0;
            c++;
        end
        for (int i = 0; i < 12; i++) begin
            if (line_done) extra_done++;
            tick();
        end
        check_val("line_done_once", done_cnt + extra_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        // BAT row 0
        mem[16'h0000] = 16'h1010;
        mem[16'h0001] = 16'h2011;
        mem[16'h0002] = 16'h3012;
        mem[16'h0003] = 16'h4013;
        mem[16'h0004] = 16'h5014;
        // tile 0x010 row 0, tile 0x011 row 0
        mem[16'h0100] = 16'h8001;
        mem[16'h0108] = 16'h4002;
        mem[16'h0110] = 16'hFFFF;
        mem[16'h0118] = 16'h0000;
        // 64x64 map, row 1 col 0: pal 7 tile 0x123, CG row 1
        mem[16'h0040] = 16'h7123;
        mem[16'h1231] = 16'h0100;
        mem[16'h1239] = 16'h0080;

        reset      = 1'b1;
        line_start = 1'b0;
        active     = 1'b1;
        bxr        = 10'd0;
        byr        = 9'd0;
        scr_w      = 2'b00;
        scr_h      = 1'b0;
        hdw        = 7'd3;

        // ---- reset state
        tick(); tick(); tick();
        check_val("rst_vram_rd",   vram_rd,   0);
        check_val("rst_vram_addr", vram_addr, 0);
        check_val("rst_slot_free", slot_free, 1);
        check_val("rst_pix_valid", pix_valid, 0);
        check_val("rst_pix_out",   pix_out,   0);
        check_val("rst_line_done", line_done, 0);
        reset = 1'b0;
        tick(); tick();
        check_val("idle_vram_rd", vram_rd, 0);

        // ---- 1: no scroll, 4 tiles
        run_line(0);
        check_val("t1_rd_count",  rd_q.size(), 15);
        check_val("t1_bat0",      rd_q[0],  16'h0000);
        check_val("t1_cg0",       rd_q[1],  16'h0100);
        check_val("t1_cg1",       rd_q[2],  16'h0108);
        check_val("t1_bat1",      rd_q[3],  16'h0001);
        check_val("t1_bat4",      rd_q[12], 16'h0004);
        check_val("t1_first_vld", first_valid, 17);
        check_val("t1_n_valid",   pix_q.size(), 32);
        check_val("t1_done_clk",  done_c, 49);
        check_val("t1_pix0",      pix_q[0],  9'h012);
        check_val("t1_pix1",      pix_q[1],  9'h018);
        check_val("t1_pix2",      pix_q[2],  9'h010);
        check_val("t1_pix6",      pix_q[6],  9'h014);
        check_val("t1_pix7",      pix_q[7],  9'h011);
        check_val("t1_pix8",      pix_q[8],  9'h023);
        check_val("t1_pix16",     pix_q[16], 9'h030);
        check_val("t1_pix31",     pix_q[31], 9'h040);

        // ---- 2: fine scroll 3, one tile
        bxr = 10'd3;
        hdw = 7'd0;
        run_line(0);
        check_val("t2_rd_count",  rd_q.size(), 6);
        check_val("t2_pv17",      pv_at[17], 0);
        check_val("t2_po17",      po_at[17], 0);
        check_val("t2_first_vld", first_valid, 20);
        check_val("t2_n_valid",   pix_q.size(), 8);
        check_val("t2_pix0",      pix_q[0], 9'h010);
        check_val("t2_pix3",      pix_q[3], 9'h014);
        check_val("t2_pix4",      pix_q[4], 9'h011);
        check_val("t2_pix5",      pix_q[5], 9'h023);
        check_val("t2_pix7",      pix_q[7], 9'h023);
        check_val("t2_done_clk",  done_c, 28);

        // ---- 3: column wrap on a 32-wide map
        bxr = 10'd248;
        hdw = 7'd1;
        run_line(0);
        check_val("t3_rd_count", rd_q.size(), 9);
        check_val("t3_bat0",     rd_q[0], 16'h001F);
        check_val("t3_bat1",     rd_q[3], 16'h0000);
        check_val("t3_bat2",     rd_q[6], 16'h0001);

        // ---- 4: 64x64 map, row 1 / pixel row 1
        bxr   = 10'd0;
        byr   = 9'd9;
        scr_w = 2'b01;
        scr_h = 1'b1;
        hdw   = 7'd0;
        run_line(0);
        check_val("t4_bat0",  rd_q[0], 16'h0040);
        check_val("t4_cg0",   rd_q[1], 16'h1231);
        check_val("t4_cg1",   rd_q[2], 16'h1239);
        check_val("t4_bat1",  rd_q[3], 16'h0041);
        check_val("t4_pix0",  pix_q[0], 9'h074);
        check_val("t4_pix7",  pix_q[7], 9'h072);
        byr = 9'd511;
        run_line(0);
        check_val("t4_row63",    rd_q[0], 16'h0FC0);
        check_val("t4_row63_cg", rd_q[1], 16'h0007);
        scr_w = 2'b11;
        scr_h = 1'b0;
        run_line(0);
        check_val("t4_w128_h32", rd_q[0], 16'h0F80);

        // ---- 5: restart during RUN at valid pixel 10
        bxr   = 10'd16;
        byr   = 9'd0;
        scr_w = 2'b00;
        scr_h = 1'b0;
        hdw   = 7'd3;
        run_line(27);
        check_val("t5_pv_before",  pv_at[27], 1);
        check_val("t5_pv_after",   pv_at[28], 0);
        check_val("t5_rd_after",   rdv_at[28], 1);
        check_val("t5_addr_after", addr_at[28], 16'h0002);
        check_val("t5_first_vld",  first_valid, 17);
        check_val("t5_n_valid",    pix_q.size(), 32);
        check_val("t5_done_clk",   done_c, 49);

        // ---- 6a: asynchronous reset mid-RUN
        bxr = 10'd0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        check_val("t6_pv_pre", pix_valid, 1);
        check_val("t6_rd_pre", vram_rd, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_vram_rd",   vram_rd,   0);
        check_val("t6_vram_addr", vram_addr, 0);
        check_val("t6_slot_free", slot_free, 1);
        check_val("t6_pix_valid", pix_valid, 0);
        check_val("t6_pix_out",   pix_out,   0);
        check_val("t6_line_done", line_done, 0);
        tick();
        reset = 1'b0;
        tick();

        // ---- 6b: active dropped mid-PREFETCH
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick(); tick(); tick();     // slot 3, next clock would read CG0
        active = 1'b0;
        tick();
        check_val("t6_inactive_rd", vram_rd, 0);
        tick();
        active = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (vram_rd || line_done) extra_done++;
            tick();
        end
        check_val("t6_stays_idle", extra_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
